// File: rtl/deparser_do_deparsing_if.sv
// ----------------------------------------------------------------------------
// deparser_do_deparsing_if
//
// Bundles every handshake and data bus of the deparser:
//   phv_in / phv_valid / phv_ready                 : PHV from the last stage
//   tdata_segs_in / segs_valid / segs_ready        : original header segments
//   out_vlan / out_vlan_valid / bram_out           : deparse action RAM port
//   deparsed_segs / deparsed_tuser / deparsed_valid
//   / deparsed_ready / deparse_err                 : rewritten header output
//
// The slave modport is the deparser's view. The master modport is the
// surrounding pipeline's view, which also plays the action RAM.
// ----------------------------------------------------------------------------
interface deparser_do_deparsing_if #(
   parameter int C_AXIS_DATA_WIDTH  = 256,
   parameter int C_AXIS_TUSER_WIDTH = 128,
   parameter int C_NUM_SEGS         = 4,
   parameter int PKT_HDR_LEN        = 1024,
   parameter int C_VLANID_WIDTH     = 12
);
   logic [PKT_HDR_LEN-1:0]                  phv_in;
   logic                                    phv_valid;
   logic                                    phv_ready;
   logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] tdata_segs_in;
   logic                                    segs_valid;
   logic                                    segs_ready;
   logic [C_VLANID_WIDTH-1:0]               out_vlan;
   logic                                    out_vlan_valid;
   logic [159:0]                            bram_out;
   logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] deparsed_segs;
   logic [C_AXIS_TUSER_WIDTH-1:0]           deparsed_tuser;
   logic                                    deparsed_valid;
   logic                                    deparsed_ready;
   logic                                    deparse_err;

   modport master (
      output phv_in, phv_valid, tdata_segs_in, segs_valid, bram_out, deparsed_ready,
      input  phv_ready, segs_ready, out_vlan, out_vlan_valid,
             deparsed_segs, deparsed_tuser, deparsed_valid, deparse_err
   );

   modport slave (
      input  phv_in, phv_valid, tdata_segs_in, segs_valid, bram_out, deparsed_ready,
      output phv_ready, segs_ready, out_vlan, out_vlan_valid,
             deparsed_segs, deparsed_tuser, deparsed_valid, deparse_err
   );
endinterface

// File: rtl/deparser_do_deparsing.sv
// ----------------------------------------------------------------------------
// deparser_do_deparsing
//
// Egress deparser. Accepts a finished PHV together with the original header
// segments, fetches the tenant's ten deparse actions from an external RAM
// (addressed by the VLAN ID in the PHV metadata), applies the actions one per
// cycle to a 128-byte header buffer and presents the rewritten header.
//
// Ports:
//   axis_clk  : clock
//   areset    : synchronous, active-high reset
//   bus       : deparser_do_deparsing_if.slave (PHV in, segments in, action
//               RAM read port, deparsed output)
//
// Action word (16 bits): [0] valid, [3:1] container index,
//   [5:4] type (01=2B, 10=4B, 11=6B, 00=no-op), [12:6] byte offset.
// Containers are stored MSB-first; field byte j lands on buffer byte off+j.
// ----------------------------------------------------------------------------
module deparser_do_deparsing #(
   parameter int C_AXIS_DATA_WIDTH  = 256,
   parameter int C_AXIS_TUSER_WIDTH = 128,
   parameter int C_NUM_SEGS         = 4,
   parameter int PKT_HDR_LEN        = 1024,
   parameter int C_VLANID_WIDTH     = 12,
   parameter int RAM_LAT            = 2
) (
   input  logic                    axis_clk,
   input  logic                    areset,
   deparser_do_deparsing_if.slave  bus
);

   localparam int BUF_W     = C_NUM_SEGS * C_AXIS_DATA_WIDTH;
   localparam int NUM_BYTES = BUF_W / 8;
   localparam int META_W    = 256;
   localparam int CONT_W    = PKT_HDR_LEN - META_W;
   localparam int VLAN_LSB  = 129;
   localparam int NUM_ACTS  = 10;
   localparam int ACT_W     = 16;
   localparam int MAX_FLD_B = 6;

   // Container base bit positions relative to the start of the container area.
   localparam int BASE_2B = 0;
   localparam int BASE_4B = 128;
   localparam int BASE_6B = 384;

   localparam int                WAIT_W    = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RAM_LAT - 1);
   localparam logic [3:0]        CNT_LAST  = 4'(NUM_ACTS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_RAM,
      S_DEPARSE,
      S_OUTPUT
   } state_t;

   // Field size in bytes is simply twice the type code.
   function automatic logic [3:0] field_bytes(input logic [1:0] typ);
      return {1'b0, typ, 1'b0};
   endfunction

   // Returns the selected container left-aligned in 48 bits, so field byte j
   // is always bits [47-8j -: 8] regardless of container size.
   function automatic logic [47:0] pick_field(input logic [CONT_W-1:0] cont,
                                              input logic [1:0]        typ,
                                              input logic [2:0]        idx);
      logic [47:0] f;
      f = '0;
      case (typ)
         2'b01:   f = {cont[BASE_2B + 16*idx +: 16], 32'h0};
         2'b10:   f = {cont[BASE_4B + 32*idx +: 32], 16'h0};
         2'b11:   f = cont[BASE_6B + 48*idx +: 48];
         default: f = '0;
      endcase
      return f;
   endfunction

   function automatic logic field_fits(input logic [6:0] off, input logic [3:0] size);
      return ({2'b00, off} + {5'b00000, size}) <= 9'(NUM_BYTES);
   endfunction

   state_t                   state_q,   state_d;
   logic [WAIT_W-1:0]        wait_q,    wait_d;
   logic [3:0]               cnt_q,     cnt_d;
   logic [ACT_W-1:0]         act_q      [NUM_ACTS];
   logic [ACT_W-1:0]         act_d      [NUM_ACTS];
   logic [CONT_W-1:0]        cont_q,    cont_d;
   logic [BUF_W-1:0]         buf_q,     buf_d;
   logic [C_AXIS_TUSER_WIDTH-1:0] tuser_q, tuser_d;
   logic [C_VLANID_WIDTH-1:0] vlan_q,   vlan_d;
   logic                     vlan_vld_q, vlan_vld_d;
   logic                     in_rdy_q,  in_rdy_d;
   logic                     out_vld_q, out_vld_d;
   logic                     err_q,     err_d;
   logic                     out_err_q, out_err_d;

   // Decode of the action selected by the counter.
   logic [ACT_W-1:0] cur_act;
   logic [2:0]       cur_idx;
   logic [1:0]       cur_typ;
   logic [6:0]       cur_off;
   logic [3:0]       cur_size;
   logic [47:0]      cur_fld;
   logic             cur_live;
   logic             cur_fits;
   logic [2:0]       unused_act_hi;
   logic             unused_phv_bits;

   assign cur_act  = act_q[cnt_q];
   assign cur_idx  = cur_act[3:1];
   assign cur_typ  = cur_act[5:4];
   assign cur_off  = cur_act[12:6];
   assign cur_size = field_bytes(cur_typ);
   assign cur_fld  = pick_field(cont_q, cur_typ, cur_idx);
   assign cur_live = cur_act[0] && (cur_typ != 2'b00);
   assign cur_fits = field_fits(cur_off, cur_size);

   assign unused_act_hi   = cur_act[15:13];
   assign unused_phv_bits = ^{bus.phv_in[META_W-1:VLAN_LSB+C_VLANID_WIDTH],
                              bus.phv_in[VLAN_LSB-1:C_AXIS_TUSER_WIDTH]};

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      cnt_d      = cnt_q;
      act_d      = act_q;
      cont_d     = cont_q;
      buf_d      = buf_q;
      tuser_d    = tuser_q;
      vlan_d     = vlan_q;
      vlan_vld_d = 1'b0;
      in_rdy_d   = in_rdy_q;
      out_vld_d  = out_vld_q;
      err_d      = err_q;
      out_err_d  = out_err_q;

      case (state_q)
         S_IDLE: begin
            // Both inputs are consumed together; a lone valid waits.
            if (bus.phv_valid && bus.segs_valid) begin
               cont_d     = bus.phv_in[PKT_HDR_LEN-1:META_W];
               buf_d      = bus.tdata_segs_in;
               tuser_d    = bus.phv_in[C_AXIS_TUSER_WIDTH-1:0];
               vlan_d     = bus.phv_in[VLAN_LSB +: C_VLANID_WIDTH];
               vlan_vld_d = 1'b1;
               in_rdy_d   = 1'b0;
               wait_d     = '0;
               state_d    = S_WAIT_RAM;
            end
         end

         S_WAIT_RAM: begin
            if (wait_q == WAIT_LAST) begin
               for (int i = 0; i < NUM_ACTS; i++) begin
                  act_d[i] = bus.bram_out[ACT_W*(NUM_ACTS-1-i) +: ACT_W];
               end
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = S_DEPARSE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end

         S_DEPARSE: begin
            if (cur_live) begin
               if (cur_fits) begin
                  for (int j = 0; j < MAX_FLD_B; j++) begin
                     if (4'(j) < cur_size) begin
                        buf_d[8*(int'(cur_off) + j) +: 8] = cur_fld[47-8*j -: 8];
                     end
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
            if (cnt_q == CNT_LAST) begin
               state_d   = S_OUTPUT;
               out_vld_d = 1'b1;
               out_err_d = err_d;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end

         S_OUTPUT: begin
            if (bus.deparsed_ready) begin
               state_d   = S_IDLE;
               out_vld_d = 1'b0;
               out_err_d = 1'b0;
               in_rdy_d  = 1'b1;
            end
         end

         default: begin
            state_d  = S_IDLE;
            in_rdy_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge axis_clk) begin
      if (areset) begin
         state_q    <= S_IDLE;
         wait_q     <= '0;
         cnt_q      <= '0;
         for (int i = 0; i < NUM_ACTS; i++) begin
            act_q[i] <= '0;
         end
         cont_q     <= '0;
         buf_q      <= '0;
         tuser_q    <= '0;
         vlan_q     <= '0;
         vlan_vld_q <= 1'b0;
         in_rdy_q   <= 1'b1;
         out_vld_q  <= 1'b0;
         err_q      <= 1'b0;
         out_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         cnt_q      <= cnt_d;
         for (int i = 0; i < NUM_ACTS; i++) begin
            act_q[i] <= act_d[i];
         end
         cont_q     <= cont_d;
         buf_q      <= buf_d;
         tuser_q    <= tuser_d;
         vlan_q     <= vlan_d;
         vlan_vld_q <= vlan_vld_d;
         in_rdy_q   <= in_rdy_d;
         out_vld_q  <= out_vld_d;
         err_q      <= err_d;
         out_err_q  <= out_err_d;
      end
   end

   assign bus.phv_ready      = in_rdy_q;
   assign bus.segs_ready     = in_rdy_q;
   assign bus.out_vlan       = vlan_q;
   assign bus.out_vlan_valid = vlan_vld_q;
   assign bus.deparsed_segs  = buf_q;
   assign bus.deparsed_tuser = tuser_q;
   assign bus.deparsed_valid = out_vld_q;
   assign bus.deparse_err    = out_err_q;

endmodule

// File: tb/tb_deparser_do_deparsing.sv
module tb_deparser_do_deparsing;
   localparam int DW = 256;
   localparam int TW = 128;
   localparam int NS = 4;
   localparam int HL = 1024;
   localparam int VW = 12;
   localparam int RL = 2;
   localparam int BW = DW * NS;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   deparser_do_deparsing_if #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(TW),
      .C_NUM_SEGS(NS), .PKT_HDR_LEN(HL), .C_VLANID_WIDTH(VW)) bus ();

   deparser_do_deparsing #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(TW),
      .C_NUM_SEGS(NS), .PKT_HDR_LEN(HL), .C_VLANID_WIDTH(VW), .RAM_LAT(RL)) dut (
      .axis_clk (clk),
      .areset   (rst),
      .bus      (bus)
   );

   // Action RAM: one-cycle registered read on the strobe; garbage on every
   // other cycle so only the latch edge may use bram_out.
   logic [159:0] ram [0:4095];
   always @(posedge clk) begin
      if (bus.out_vlan_valid) bus.bram_out <= ram[bus.out_vlan];
      else bus.bram_out <= {$urandom, $urandom, $urandom, $urandom, $urandom};
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_segs(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      int k;
      k = 0;
      for (int i = BW/8 - 1; i >= 0; i--) if (obs[8*i +: 8] !== exp[8*i +: 8]) k = i;
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: first bad byte %0d observed=%h expected=%h", tag, k, obs[8*k +: 8], exp[8*k +: 8]);
      end
   endtask

   function automatic logic [15:0] mk_act(input bit v, input int typ, input int idx, input int off);
      return {3'b000, 7'(off), 2'(typ), 3'(idx), v};
   endfunction

   function automatic logic [159:0] put_act(input logic [159:0] acts, input int i, input logic [15:0] a);
      logic [159:0] r;
      r = acts;
      r[144 - 16*i +: 16] = a;
      return r;
   endfunction

   function automatic logic [BW-1:0] rand_wide();
      logic [BW-1:0] r;
      for (int w = 0; w < BW/32; w++) r[32*w +: 32] = $urandom;
      return r;
   endfunction

   // Reference: a byte array rewritten by each action in order.
   function automatic void model(input logic [HL-1:0] phv, input logic [BW-1:0] segs,
                                 input logic [159:0] acts,
                                 output logic [BW-1:0] o, output logic err);
      byte unsigned b [128];
      int typ, idx, off, size, base;
      logic [15:0] a;
      for (int k = 0; k < 128; k++) b[k] = segs[8*k +: 8];
      err = 1'b0;
      for (int i = 0; i < 10; i++) begin
         a   = acts[144 - 16*i +: 16];
         typ = int'(a[5:4]);
         idx = int'(a[3:1]);
         off = int'(a[12:6]);
         if (a[0] && typ != 0) begin
            size = 2 * typ;
            if (off + size > 128) begin
               err = 1'b1;
            end else begin
               base = (typ == 1) ? 256 : (typ == 2) ? 384 : 640;
               base = base + size * 8 * idx;
               for (int j = 0; j < size; j++) b[off + j] = phv[base + 8*(size - 1 - j) +: 8];
            end
         end
      end
      for (int k = 0; k < 128; k++) o[8*k +: 8] = b[k];
   endfunction

   // Called and returns just after a falling edge.
   task automatic run_packet(input string name, input logic [HL-1:0] phv, input logic [BW-1:0] segs,
                             input logic [159:0] acts, input int pre, input int hold,
                             output logic [BW-1:0] got, output logic got_err);
      logic [BW-1:0] exp_segs;
      logic exp_err;
      int k;
      bit busy_bad, stable_bad;
      model(phv, segs, acts, exp_segs, exp_err);
      ram[phv[140:129]] = acts;
      bus.phv_in = phv;
      bus.tdata_segs_in = segs;
      bus.phv_valid = 1'b1;
      bus.segs_valid = (pre == 0);
      for (int p = 0; p < pre; p++) begin
         @(negedge clk);
         chk({name, " lone_phv_no_accept"}, {bus.phv_ready, bus.segs_ready, bus.out_vlan_valid}, 3'b110);
      end
      bus.segs_valid = 1'b1;
      chk({name, " ready_at_accept"}, bus.phv_ready, 1);
      @(negedge clk);
      bus.phv_valid = 1'b0;
      bus.segs_valid = 1'b0;
      bus.phv_in = rand_wide();
      bus.tdata_segs_in = rand_wide();
      chk({name, " vlan_strobe"}, bus.out_vlan_valid, 1);
      chk({name, " vlan"}, bus.out_vlan, phv[140:129]);
      k = 1;
      busy_bad = 0;
      while (bus.deparsed_valid !== 1'b1 && k < 40) begin
         if (bus.phv_ready !== 1'b0 || bus.segs_ready !== 1'b0) busy_bad = 1;
         if (k >= 2 && bus.out_vlan_valid !== 1'b0) busy_bad = 1;
         @(negedge clk);
         k++;
      end
      chk({name, " latency"}, k, 13);
      chk({name, " busy_ctrl"}, busy_bad, 0);
      got = bus.deparsed_segs;
      got_err = bus.deparse_err;
      chk_segs({name, " segs"}, got, exp_segs);
      chk({name, " err"}, got_err, exp_err);
      chk({name, " tuser_lo"}, bus.deparsed_tuser[63:0], phv[63:0]);
      chk({name, " tuser_hi"}, bus.deparsed_tuser[127:64], phv[127:64]);
      stable_bad = 0;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         if (bus.deparsed_valid !== 1'b1 || bus.deparsed_segs !== exp_segs ||
             bus.deparse_err !== exp_err || bus.phv_ready !== 1'b0) stable_bad = 1;
      end
      if (hold > 0) chk({name, " hold_stable"}, stable_bad, 0);
      bus.deparsed_ready = 1'b1;
      @(negedge clk);
      bus.deparsed_ready = 1'b0;
      chk({name, " after_hs"}, {bus.deparsed_valid, bus.phv_ready, bus.segs_ready}, 3'b011);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [HL-1:0] phv;
      logic [BW-1:0] segs, got;
      logic [159:0] acts;
      logic got_err;

      rst = 1'b1;
      bus.phv_in = '0;
      bus.phv_valid = 1'b0;
      bus.tdata_segs_in = '0;
      bus.segs_valid = 1'b0;
      bus.deparsed_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset ctrl", {bus.phv_ready, bus.segs_ready, bus.out_vlan_valid, bus.deparsed_valid, bus.deparse_err}, 5'b11000);
      chk("reset segs_zero", {63'd0, |bus.deparsed_segs}, 0);
      chk("reset vlan", bus.out_vlan, 0);

      // 6B container to offset 0
      phv = rand_wide();
      phv[640 +: 48] = 48'h001122334455;
      phv[129 +: 12] = 12'h001;
      segs = {128{8'hAA}};
      acts = put_act('0, 0, mk_act(1, 3, 0, 0));
      run_packet("t1", phv, segs, acts, 0, 0, got, got_err);
      chk("t1 bytes0_5", got[47:0], 48'h554433221100);
      chk("t1 byte6", got[55:48], 8'hAA);
      chk("t1 err", got_err, 0);

      // 2B and 4B writes, other actions invalid
      phv = rand_wide();
      phv[304 +: 16] = 16'hBEEF;
      phv[416 +: 32] = 32'hC0A80001;
      phv[129 +: 12] = 12'h0A5;
      segs = rand_wide();
      acts = put_act('0, 0, mk_act(0, 3, 0, 0));
      acts = put_act(acts, 2, mk_act(1, 1, 3, 12));
      acts = put_act(acts, 7, mk_act(1, 2, 1, 26));
      run_packet("t2", phv, segs, acts, 0, 0, got, got_err);
      chk("t2 bytes12_13", got[96 +: 16], 16'hEFBE);
      chk("t2 bytes26_29", got[208 +: 32], 32'h0100A8C0);
      chk("t2 byte0", got[7:0], segs[7:0]);

      // Overlap: higher index wins
      phv = rand_wide();
      phv[384 +: 32] = 32'h11111111;
      phv[256 +: 16] = 16'h2222;
      phv[129 +: 12] = 12'h7FF;
      segs = rand_wide();
      acts = put_act('0, 1, mk_act(1, 2, 0, 10));
      acts = put_act(acts, 5, mk_act(1, 1, 0, 11));
      run_packet("t3", phv, segs, acts, 0, 0, got, got_err);
      chk("t3 bytes10_13", got[80 +: 32], 32'h11222211);

      // Out-of-range 6B write is skipped and flagged
      phv = rand_wide();
      phv[129 +: 12] = 12'h123;
      segs = {128{8'hAA}};
      acts = put_act('0, 0, mk_act(1, 3, 2, 124));
      run_packet("t4", phv, segs, acts, 0, 0, got, got_err);
      chk("t4 err", got_err, 1);
      chk_segs("t4 unchanged", got, segs);

      // Lone phv_valid before, backpressure in OUTPUT, then accept waits for segs
      phv = rand_wide();
      segs = rand_wide();
      acts = rand_wide();
      run_packet("t5", phv, segs, acts, 3, 5, got, got_err);
      phv = rand_wide();
      segs = rand_wide();
      acts = rand_wide();
      run_packet("t5b", phv, segs, acts, 2, 0, got, got_err);

      // Reset in the middle of DEPARSE (cnt=4) with err already set
      phv = rand_wide();
      phv[129 +: 12] = 12'h055;
      acts = put_act(rand_wide(), 0, mk_act(1, 3, 0, 124));
      ram[12'h055] = acts;
      bus.phv_in = phv;
      bus.tdata_segs_in = rand_wide();
      bus.phv_valid = 1'b1;
      bus.segs_valid = 1'b1;
      @(negedge clk);
      bus.phv_valid = 1'b0;
      bus.segs_valid = 1'b0;
      chk("t6 strobe", bus.out_vlan_valid, 1);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6 after_reset", {bus.deparsed_valid, bus.out_vlan_valid, bus.phv_ready, bus.segs_ready, bus.deparse_err}, 5'b00110);
      phv = rand_wide();
      phv[129 +: 12] = 12'h056;
      segs = rand_wide();
      acts = put_act('0, 4, mk_act(1, 2, 5, 100));
      run_packet("t6b", phv, segs, acts, 0, 0, got, got_err);
      chk("t6b err_clear", got_err, 0);

      // Random traffic
      for (int n = 0; n < 16; n++) begin
         phv = rand_wide();
         segs = rand_wide();
         acts = '0;
         for (int i = 0; i < 10; i++) begin
            acts = put_act(acts, i, mk_act($urandom_range(0, 3) != 0, $urandom_range(0, 3),
                           $urandom_range(0, 7),
                           ($urandom_range(0, 3) == 0) ? $urandom_range(118, 127) : $urandom_range(0, 117)));
         end
         run_packet($sformatf("rnd%0d", n), phv, segs, acts, $urandom_range(0, 2), $urandom_range(0, 3), got, got_err);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
